// File: rtl/tsc_pkg.sv
// ============================================================================
// Module : tsc_pkg
// Brief  : Shared lamp codes, phase encodings and lamp helper for the
//          intersection phase scheduler.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package tsc_pkg;

    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b110;
    localparam logic [2:0] LAMP_GRN = 3'b010;

    typedef enum logic [1:0] {
        PH_ALLRED = 2'b00,
        PH_GREEN  = 2'b01,
        PH_YELLOW = 2'b10
    } phase_t;

    // Lamp code shown by the owning approach in a given phase.
    function automatic logic [2:0] lamp_for(input phase_t ph);
        case (ph)
            PH_GREEN:  return LAMP_GRN;
            PH_YELLOW: return LAMP_YEL;
            default:   return LAMP_RED;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module : rr_arbiter
// Brief  : Combinational rotate-priority arbiter; search starts at ptr+1 and
//          wraps, so ptr itself has the lowest priority.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [IW-1:0] o_gnt_idx,
    output logic          o_gnt_valid
);

    logic [IW:0] w_sum;

    // Walk from lowest to highest priority; the last hit is the winner.
    always_comb begin
        o_gnt_idx   = '0;
        o_gnt_valid = 1'b0;
        w_sum       = '0;
        for (int k = N; k >= 1; k--) begin
            w_sum = {1'b0, i_ptr} + (IW+1)'(k);
            if (w_sum >= (IW+1)'(N)) begin
                w_sum = w_sum - (IW+1)'(N);
            end
            if (i_req[w_sum[IW-1:0]]) begin
                o_gnt_idx   = w_sum[IW-1:0];
                o_gnt_valid = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/intersection_phase_scheduler.sv
// ============================================================================
// Module : intersection_phase_scheduler
// Brief  : Round-robin right-of-way scheduler with min/max green, yellow and
//          all-red clearance; drives registered {R,Y,G} lamp codes.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module intersection_phase_scheduler #(
    parameter int N_APPR    = 4,
    parameter int TW        = 8,
    parameter int MIN_GREEN = 4,
    parameter int MAX_GREEN = 20,
    parameter int YELLOW    = 3,
    parameter int ALL_RED   = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_tick,
    input  logic [N_APPR-1:0]           i_req,
    output logic [3*N_APPR-1:0]         o_rgb,
    output logic [$clog2(N_APPR)-1:0]   o_owner,
    output logic [1:0]                  o_phase,
    output logic                        o_served
);

    import tsc_pkg::*;

    localparam int IW = $clog2(N_APPR);
    localparam logic [TW-1:0] c_MIN_GREEN = TW'(MIN_GREEN);
    localparam logic [TW-1:0] c_MAX_GREEN = TW'(MAX_GREEN);
    localparam logic [TW-1:0] c_YELLOW    = TW'(YELLOW);
    localparam logic [TW-1:0] c_ALL_RED   = TW'(ALL_RED);

    phase_t              r_phase;
    phase_t              w_next_phase;
    logic [TW-1:0]       r_elapsed;
    logic [TW-1:0]       w_el_eff;
    logic [TW:0]         w_el_sum;
    logic [IW-1:0]       r_owner;
    logic [IW-1:0]       w_next_owner;
    logic [IW-1:0]       w_gnt_idx;
    logic                w_gnt_valid;
    logic [N_APPR-1:0]   w_owner_oh;
    logic                w_others;
    logic [3*N_APPR-1:0] r_rgb;
    logic [3*N_APPR-1:0] w_next_rgb;
    logic                r_served;

    // Elapsed including this clock's tick, so a coincident tick counts.
    assign w_el_sum   = {1'b0, r_elapsed} + {{TW{1'b0}}, i_tick};
    assign w_el_eff   = w_el_sum[TW] ? {TW{1'b1}} : w_el_sum[TW-1:0];
    assign w_owner_oh = {{(N_APPR-1){1'b0}}, 1'b1} << r_owner;
    assign w_others   = |(i_req & ~w_owner_oh);

    rr_arbiter #(
        .N  (N_APPR),
        .IW (IW)
    ) u_arb (
        .i_req       (i_req),
        .i_ptr       (r_owner),
        .o_gnt_idx   (w_gnt_idx),
        .o_gnt_valid (w_gnt_valid)
    );

    always_comb begin
        w_next_phase = r_phase;
        w_next_owner = r_owner;
        w_next_rgb   = {N_APPR{LAMP_RED}};
        case (r_phase)
            PH_ALLRED: begin
                if ((w_el_eff >= c_ALL_RED) && w_gnt_valid) begin
                    w_next_phase = PH_GREEN;
                    w_next_owner = w_gnt_idx;
                end
            end
            PH_GREEN: begin
                if ((w_el_eff >= c_MIN_GREEN) && w_others &&
                    (!i_req[r_owner] || (w_el_eff >= c_MAX_GREEN))) begin
                    w_next_phase = PH_YELLOW;
                end
            end
            PH_YELLOW: begin
                if (w_el_eff >= c_YELLOW) begin
                    w_next_phase = PH_ALLRED;
                end
            end
            default: begin
                w_next_phase = PH_ALLRED;
            end
        endcase
        for (int i = 0; i < N_APPR; i++) begin
            if (IW'(i) == w_next_owner) begin
                w_next_rgb[3*i +: 3] = lamp_for(w_next_phase);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_phase   <= PH_ALLRED;
            r_elapsed <= '0;
            r_owner   <= IW'(N_APPR - 1);
            r_rgb     <= {N_APPR{LAMP_RED}};
            r_served  <= 1'b0;
        end else begin
            r_phase   <= w_next_phase;
            r_elapsed <= (w_next_phase != r_phase) ? '0 : w_el_eff;
            r_owner   <= w_next_owner;
            r_rgb     <= w_next_rgb;
            r_served  <= (w_next_phase == PH_GREEN) && (r_phase != PH_GREEN);
        end
    end

    assign o_rgb    = r_rgb;
    assign o_owner  = r_owner;
    assign o_phase  = r_phase;
    assign o_served = r_served;

endmodule

`default_nettype wire

// File: tb/tb_intersection_phase_scheduler.sv
// ============================================================================
// Module : tb_intersection_phase_scheduler
// Brief  : Self-checking bench with a behavioural scheduler model and
//          directed plus randomized stimulus.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_intersection_phase_scheduler;

    localparam int N    = 4;
    localparam int TW   = 8;
    localparam int MING = 2;
    localparam int MAXG = 5;
    localparam int YEL  = 2;
    localparam int AR   = 1;
    localparam int SAT  = (1 << TW) - 1;

    logic             clk    = 1'b0;
    logic             rst    = 1'b1;
    logic             i_tick = 1'b1;
    logic [N-1:0]     i_req  = '0;
    logic [3*N-1:0]   o_rgb;
    logic [1:0]       o_owner;
    logic [1:0]       o_phase;
    logic             o_served;

    always #5 clk = ~clk;

    intersection_phase_scheduler #(
        .N_APPR    (N),
        .TW        (TW),
        .MIN_GREEN (MING),
        .MAX_GREEN (MAXG),
        .YELLOW    (YEL),
        .ALL_RED   (AR)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .i_tick   (i_tick),
        .i_req    (i_req),
        .o_rgb    (o_rgb),
        .o_owner  (o_owner),
        .o_phase  (o_phase),
        .o_served (o_served)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: phase 0=all-red, 1=green, 2=yellow; m_el = ticks since phase start.
    int m_phase, m_el, m_owner;
    bit m_served;

    function automatic int exp_rgb(input int ph, input int own);
        int r;
        int code;
        r = 0;
        for (int i = 0; i < N; i++) begin
            code = 4;
            if (i == own) code = (ph == 1) ? 2 : (ph == 2) ? 6 : 4;
            r = r | (code << (3 * i));
        end
        return r;
    endfunction

    task automatic model_step();
        int el, nph, nown;
        bit others, found;
        el   = m_el + int'(i_tick);
        if (el > SAT) el = SAT;
        nph  = m_phase;
        nown = m_owner;
        if (m_phase == 0) begin
            found = 0;
            if (el >= AR) begin
                for (int k = 1; k <= N; k++) begin
                    if (!found && i_req[(m_owner + k) % N]) begin
                        found = 1;
                        nown  = (m_owner + k) % N;
                        nph   = 1;
                    end
                end
            end
        end else if (m_phase == 1) begin
            others = 0;
            for (int j = 0; j < N; j++) if (j != m_owner && i_req[j]) others = 1;
            if (el >= MING && others && (!i_req[m_owner] || el >= MAXG)) nph = 2;
        end else begin
            if (el >= YEL) nph = 0;
        end
        m_served = (nph == 1) && (m_phase != 1);
        m_el     = (nph != m_phase) ? 0 : el;
        m_phase  = nph;
        m_owner  = nown;
    endtask

    initial begin
        m_phase = 0; m_el = 0; m_owner = N - 1; m_served = 0;
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_phase = 0; m_el = 0; m_owner = N - 1; m_served = 0;
            end else begin
                model_step();
            end
        end
    end

    initial begin
        int greens;
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("model_phase",  32'(o_phase),  32'(m_phase));
                chk("model_owner",  32'(o_owner),  32'(m_owner));
                chk("model_rgb",    32'(o_rgb),    32'(exp_rgb(m_phase, m_owner)));
                chk("model_served", 32'(o_served), 32'(m_served));
                greens = 0;
                for (int i = 0; i < N; i++) if (o_rgb[3*i +: 3] == 3'b010) greens++;
                chk("single_green", 32'(greens <= 1), 32'd1);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [N-1:0] r);
        rst   = 1'b1;
        i_req = r;
        @(posedge clk);
        @(negedge clk);
        chk("rst_phase",  32'(o_phase),  32'd0);
        chk("rst_rgb",    32'(o_rgb),    32'h924);
        chk("rst_owner",  32'(o_owner),  32'd3);
        chk("rst_served", 32'(o_served), 32'd0);
        rst = 1'b0;
    endtask

    task automatic expect_run(input int ph, input int own, input int n);
        repeat (n) begin
            cyc();
            chk($sformatf("run_phase%0d_own%0d", ph, own), 32'(o_phase), 32'(ph));
            chk($sformatf("run_owner%0d", own), 32'(o_owner), 32'(own));
            chk($sformatf("run_rgb%0d_own%0d", ph, own), 32'(o_rgb), 32'(exp_rgb(ph, own)));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int seq [5];
        seq = '{0, 1, 2, 3, 0};

        // Idle: no requests, all red, no service.
        do_reset(4'b0000);
        repeat (50) begin
            cyc();
            chk("idle_phase",  32'(o_phase),  32'd0);
            chk("idle_rgb",    32'(o_rgb),    32'h924);
            chk("idle_served", 32'(o_served), 32'd0);
        end

        // Single request granted, then rests green without demand.
        i_req = 4'b0001;
        cyc();
        chk("grant_phase",  32'(o_phase),  32'd1);
        chk("grant_owner",  32'(o_owner),  32'd0);
        chk("grant_rgb",    32'(o_rgb),    32'h922);
        chk("grant_served", 32'(o_served), 32'd1);
        i_req = 4'b0000;
        cyc();
        chk("served_once", 32'(o_served), 32'd0);
        expect_run(1, 0, 20);

        // Owner keeps requesting: max green, then handoff to approach 2.
        do_reset(4'b0101);
        expect_run(1, 0, 5);
        expect_run(2, 0, 2);
        chk("yellow_rgb0", 32'(o_rgb), 32'h926);
        expect_run(0, 0, 1);
        expect_run(1, 2, 5);
        expect_run(2, 2, 2);
        expect_run(0, 2, 1);
        expect_run(1, 0, 1);

        // Full demand: strict rotation, 5 ticks of green each.
        do_reset(4'b1111);
        foreach (seq[s]) begin
            expect_run(1, seq[s], 5);
            expect_run(2, seq[s], 2);
            expect_run(0, seq[s], 1);
        end

        // Owner demand drops right after entry: minimum green still honoured.
        do_reset(4'b0001);
        cyc();
        chk("min_entry_phase", 32'(o_phase), 32'd1);
        i_req = 4'b0100;
        expect_run(1, 0, 1);
        expect_run(2, 0, 2);
        expect_run(0, 0, 1);
        expect_run(1, 2, 1);

        // Asynchronous reset in the middle of yellow.
        do_reset(4'b1111);
        expect_run(1, 0, 5);
        cyc();
        chk("pre_rst_yellow", 32'(o_phase), 32'd2);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rgb",   32'(o_rgb),   32'h924);
        chk("async_phase", 32'(o_phase), 32'd0);
        chk("async_owner", 32'(o_owner), 32'd3);
        i_req = 4'b1000;
        @(negedge clk);
        rst = 1'b0;
        cyc();
        chk("restart_phase",  32'(o_phase),  32'd1);
        chk("restart_owner",  32'(o_owner),  32'd3);
        chk("restart_served", 32'(o_served), 32'd1);

        // Randomized demand and timebase, checked by the model every cycle.
        do_reset(N'($urandom));
        for (int it = 0; it < 3000; it++) begin
            if (it == 1500) do_reset(N'($urandom));
            i_tick = ($urandom_range(3) != 0);
            if ($urandom_range(7) == 0) i_req = N'($urandom);
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
